// File: rtl/bankmachine_param.sv
// Per-bank LPDDR4 command scheduler: lookahead FIFO, open-row tracking, bank timing timers,
// open/close-page policy with auto-precharge, idle-timeout precharge and refresh hand-off.
module bankmachine_param #(
  parameter int ADDR_W    = 23,
  parameter int COL_W     = 6,
  parameter int A_W       = 17,
  parameter int BA_W      = 3,
  parameter int BANK_ID   = 0,
  parameter int DEPTH     = 8,
  parameter int TMR_W     = 8,
  parameter int IDLE_TO_W = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 req_lock,
  output logic                 req_wdata_ready,
  output logic                 req_rdata_valid,
  input  logic                 refresh_req,
  output logic                 refresh_gnt,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [A_W-1:0]       cmd_payload_a,
  output logic [BA_W-1:0]      cmd_payload_ba,
  output logic                 cmd_payload_cas,
  output logic                 cmd_payload_ras,
  output logic                 cmd_payload_we,
  output logic                 cmd_payload_is_cmd,
  output logic                 cmd_payload_is_read,
  output logic                 cmd_payload_is_write,
  input  logic                 close_page,
  input  logic [IDLE_TO_W-1:0] idle_timeout_cfg,
  input  logic [TMR_W-1:0]     cfg_tWTP,
  input  logic [TMR_W-1:0]     cfg_tRC,
  input  logic [TMR_W-1:0]     cfg_tRAS,
  input  logic [TMR_W-1:0]     cfg_tRP,
  input  logic [TMR_W-1:0]     cfg_tRCD,
  output logic                 row_open_o
);
  localparam int ROW_W = ADDR_W - COL_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int NT    = 5;
  localparam int T_WTP = 0, T_RC = 1, T_RAS = 2, T_RP = 3, T_RCD = 4;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_AP_WAIT, S_TRP, S_ACT, S_TRCD, S_REFRESH} state_t;

  logic [ADDR_W:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 buf_valid_q, buf_we_q;
  logic [ADDR_W-1:0]    buf_addr_q;
  logic [ROW_W-1:0]     open_row_q;
  logic                 row_open_q;
  logic [IDLE_TO_W-1:0] idle_cnt_q;
  state_t               state_q;

  logic                 fifo_empty, push, pop, ap, hit, idle_expired;
  logic                 cmd_fire, col_fire;
  logic [ADDR_W:0]      head;
  logic [ROW_W-1:0]     buf_row;
  logic [DEPTH-1:0]     same_row;
  logic [NT-1:0]        tmr_rdy, tmr_load;
  logic [NT-1:0][TMR_W-1:0] tmr_cfg;

  logic                 v_c, cas_c, ras_c, we_c, is_cmd_c, is_rd_c, is_wr_c;
  logic [A_W-1:0]       a_c;

  assign fifo_empty = (level_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign buf_row    = buf_addr_q[ADDR_W-1:COL_W];
  assign hit        = row_open_q && (buf_row == open_row_q);
  assign push       = req_valid && (level_q != LVL_W'(DEPTH));
  assign pop        = (!buf_valid_q || col_fire) && !fifo_empty;
  assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
  assign idle_expired = row_open_q && (idle_timeout_cfg != '0) && (idle_cnt_q == idle_timeout_cfg);

  genvar gi;
  // Close the row early if the next request misses, or (close-page) nothing queued reuses it.
  for (gi = 0; gi < DEPTH; gi++) begin : g_look
    logic [PTR_W-1:0] offs;
    assign offs = PTR_W'(gi) - rd_ptr_q;
    assign same_row[gi] = ({1'b0, offs} < level_q) && (fifo_q[gi][ADDR_W-1:COL_W] == buf_row);
  end
  assign ap = (!fifo_empty && (head[ADDR_W-1:COL_W] != buf_row)) || (close_page && (same_row == '0));

  assign tmr_cfg = {cfg_tRCD, cfg_tRP, cfg_tRAS, cfg_tRC, cfg_tWTP};
  always_comb begin
    tmr_load        = '0;
    tmr_load[T_RC]  = cmd_fire && (state_q == S_ACT);
    tmr_load[T_RAS] = cmd_fire && (state_q == S_ACT);
    tmr_load[T_RCD] = cmd_fire && (state_q == S_ACT);
    tmr_load[T_RP]  = (cmd_fire && (state_q == S_PRE)) || (col_fire && ap);
    tmr_load[T_WTP] = col_fire && buf_we_q;
  end

  // A load of 0 behaves like 1: ready drops for exactly max(C,1) cycles.
  for (gi = 0; gi < NT; gi++) begin : g_tmr
    logic [TMR_W-1:0] cnt_q;
    logic             rdy_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_q <= '0;
        rdy_q <= 1'b0;
      end else if (tmr_load[gi]) begin
        cnt_q <= (tmr_cfg[gi] == '0) ? '0 : tmr_cfg[gi] - TMR_W'(1);
        rdy_q <= 1'b0;
      end else if (cnt_q == '0) begin
        rdy_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - TMR_W'(1);
      end
    end
    assign tmr_rdy[gi] = rdy_q;
  end

  always_comb begin
    v_c = 1'b0; cas_c = 1'b0; ras_c = 1'b0; we_c = 1'b0;
    is_cmd_c = 1'b0; is_rd_c = 1'b0; is_wr_c = 1'b0;
    a_c = '0;
    case (state_q)
      S_IDLE: begin
        v_c     = buf_valid_q && hit && !refresh_req;
        cas_c   = v_c;
        we_c    = v_c && buf_we_q;
        is_rd_c = v_c && !buf_we_q;
        is_wr_c = v_c && buf_we_q;
        a_c[COL_W+3:4] = buf_addr_q[COL_W-1:0];
        a_c[10] = ap;
      end
      S_PRE: begin
        v_c = tmr_rdy[T_WTP] && tmr_rdy[T_RAS];
        ras_c = 1'b1; we_c = 1'b1; is_cmd_c = 1'b1;
      end
      S_ACT: begin
        v_c = tmr_rdy[T_RC];
        ras_c = 1'b1; is_cmd_c = 1'b1;
        a_c[ROW_W-1:0] = buf_row;
      end
      default: ;
    endcase
  end

  assign cmd_fire = v_c && cmd_ready;
  assign col_fire = cmd_fire && (state_q == S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (push) fifo_q[wr_ptr_q] <= {req_we, req_addr};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0;
      buf_valid_q <= 1'b0; buf_we_q <= 1'b0; buf_addr_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        buf_valid_q <= 1'b1;
        {buf_we_q, buf_addr_q} <= head;
      end else if (col_fire) begin
        buf_valid_q <= 1'b0;
      end
      if (cmd_fire || buf_valid_q || !fifo_empty) idle_cnt_q <= '0;
      else if (idle_cnt_q != '1) idle_cnt_q <= idle_cnt_q + IDLE_TO_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE; row_open_q <= 1'b0; open_row_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (refresh_req) state_q <= row_open_q ? S_PRE : S_REFRESH;
          else if (buf_valid_q) begin
            if (!row_open_q) state_q <= S_ACT;
            else if (!hit) state_q <= S_PRE;
            else if (col_fire && ap) begin
              state_q <= S_AP_WAIT;
              row_open_q <= 1'b0;
            end
          end else if (idle_expired) state_q <= S_PRE;
        end
        S_PRE: if (cmd_fire) begin
          state_q <= S_TRP;
          row_open_q <= 1'b0;
        end
        S_AP_WAIT: if (tmr_rdy[T_WTP] && tmr_rdy[T_RAS]) state_q <= S_TRP;
        S_TRP: if (tmr_rdy[T_RP]) state_q <= (buf_valid_q && !refresh_req) ? S_ACT : S_IDLE;
        S_ACT: if (cmd_fire) begin
          state_q <= S_TRCD;
          row_open_q <= 1'b1;
          open_row_q <= buf_row;
        end
        S_TRCD: if (tmr_rdy[T_RCD]) state_q <= S_IDLE;
        S_REFRESH: begin
          row_open_q <= 1'b0;
          if (!refresh_req) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every combinational output is forced low while reset is asserted.
  assign req_ready            = sys_rst_n && (level_q != LVL_W'(DEPTH));
  assign req_lock             = sys_rst_n && (buf_valid_q || !fifo_empty);
  assign req_wdata_ready      = sys_rst_n && col_fire && buf_we_q;
  assign req_rdata_valid      = sys_rst_n && col_fire && !buf_we_q;
  assign refresh_gnt          = sys_rst_n && (state_q == S_REFRESH) && tmr_rdy[T_WTP];
  assign cmd_valid            = sys_rst_n && v_c;
  assign cmd_payload_a        = sys_rst_n ? a_c : '0;
  assign cmd_payload_ba       = sys_rst_n ? BA_W'(BANK_ID) : '0;
  assign cmd_payload_cas      = sys_rst_n && cas_c;
  assign cmd_payload_ras      = sys_rst_n && ras_c;
  assign cmd_payload_we       = sys_rst_n && we_c;
  assign cmd_payload_is_cmd   = sys_rst_n && is_cmd_c;
  assign cmd_payload_is_read  = sys_rst_n && is_rd_c;
  assign cmd_payload_is_write = sys_rst_n && is_wr_c;
  assign row_open_o           = sys_rst_n && row_open_q;
endmodule

// File: tb/tb_bankmachine_param.sv
// Self-checking bench for bankmachine_param: scoreboard of expected column commands plus
// directed checks on ACT/PRE counts, page policy, refresh, idle timeout and FIFO backpressure.
module tb_bankmachine_param;
  localparam int ADDR_W = 23, COL_W = 6, A_W = 17, BA_W = 3, DEPTH = 8, TMR_W = 8, IDLE_TO_W = 8;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, refresh_req = 1'b0, cmd_ready = 1'b1, close_page = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [IDLE_TO_W-1:0] idle_timeout_cfg = '0;
  logic [TMR_W-1:0] cfg_tWTP = 8'd2, cfg_tRC = 8'd2, cfg_tRAS = 8'd2, cfg_tRP = 8'd2, cfg_tRCD = 8'd2;
  logic req_ready, req_lock, req_wdata_ready, req_rdata_valid, refresh_gnt, cmd_valid;
  logic [A_W-1:0] cmd_payload_a;
  logic [BA_W-1:0] cmd_payload_ba;
  logic cmd_payload_cas, cmd_payload_ras, cmd_payload_we;
  logic cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write, row_open_o;

  bankmachine_param dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_lock(req_lock), .req_wdata_ready(req_wdata_ready), .req_rdata_valid(req_rdata_valid),
    .refresh_req(refresh_req), .refresh_gnt(refresh_gnt),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_a(cmd_payload_a),
    .cmd_payload_ba(cmd_payload_ba), .cmd_payload_cas(cmd_payload_cas),
    .cmd_payload_ras(cmd_payload_ras), .cmd_payload_we(cmd_payload_we),
    .cmd_payload_is_cmd(cmd_payload_is_cmd), .cmd_payload_is_read(cmd_payload_is_read),
    .cmd_payload_is_write(cmd_payload_is_write),
    .close_page(close_page), .idle_timeout_cfg(idle_timeout_cfg),
    .cfg_tWTP(cfg_tWTP), .cfg_tRC(cfg_tRC), .cfg_tRAS(cfg_tRAS), .cfg_tRP(cfg_tRP), .cfg_tRCD(cfg_tRCD),
    .row_open_o(row_open_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic we; logic [A_W-1:0] a; } exp_t;
  exp_t exp_q[$];

  int cyc = 0, act_cnt = 0, pre_cnt = 0, col_cnt = 0;
  int act_cyc = 0, pre_cyc = 0, col_cyc = 0;
  logic [A_W-1:0] last_act_a = '0;

  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (sys_rst_n && cmd_valid && cmd_ready) begin
      if (cmd_payload_ras && !cmd_payload_cas && !cmd_payload_we) begin
        act_cnt++; act_cyc = cyc; last_act_a = cmd_payload_a;
        $display("txn ACT a=0x%0h cyc=%0d", cmd_payload_a, cyc);
      end
      if (cmd_payload_ras && cmd_payload_we && !cmd_payload_cas) begin
        pre_cnt++; pre_cyc = cyc;
        $display("txn PRE cyc=%0d", cyc);
      end
      if (cmd_payload_cas) begin
        col_cnt++; col_cyc = cyc;
        $display("txn %s a=0x%0h cyc=%0d", cmd_payload_we ? "WR" : "RD", cmd_payload_a, cyc);
        if (exp_q.size() == 0) check_eq("sb_underflow", 0, 1);
        else begin
          e = exp_q.pop_front();
          check_eq("col_a", 32'(cmd_payload_a), 32'(e.a));
          check_eq("col_we", 32'(cmd_payload_we), 32'(e.we));
          check_eq("col_is_write", 32'(cmd_payload_is_write), 32'(e.we));
          check_eq("rdata_valid", 32'(req_rdata_valid), 32'(!e.we));
          check_eq("wdata_ready", 32'(req_wdata_ready), 32'(e.we));
          check_eq("bank_id", 32'(cmd_payload_ba), 0);
        end
      end
    end
  end

  function automatic exp_t mk(input logic we, input int col, input logic ap);
    exp_t e;
    e.we = we;
    e.a = A_W'(col << 4) | (ap ? A_W'(1 << 10) : '0);
    return e;
  endfunction

  task automatic send(input logic we, input int row, input int col, input logic ap);
    bit ok = 0;
    exp_q.push_back(mk(we, col, ap));
    @(posedge sys_clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = ADDR_W'((row << COL_W) | col);
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) check_eq("req_accept_timeout", 0, 1);
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge sys_clk);
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, n, gap, rd_cyc;
    bit seen;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_row_open", row_open_o, 0);
    check_eq("rst_req_lock", req_lock, 0);
    check_eq("rst_refresh_gnt", refresh_gnt, 0);
    @(posedge sys_clk); #1; sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_eq("post_rst_req_ready", req_ready, 1);
    check_eq("post_rst_req_lock", req_lock, 0);

    // Read row 5 col 3 from a closed bank.
    a0 = act_cnt;
    send(1'b0, 5, 3, 1'b0);
    drain("s1_drain");
    check_eq("s1_act_count", act_cnt - a0, 1);
    check_eq("s1_act_row", 32'(last_act_a), 5);
    gap = col_cyc - act_cyc;
    check_eq("s1_act_to_rd_gap_ok", (gap >= 2 && gap <= 6), 1);
    check_eq("s1_row_open", row_open_o, 1);

    // Two writes to the open row under open-page policy: no new ACT, no AP.
    a0 = act_cnt;
    send(1'b1, 5, 1, 1'b0);
    send(1'b1, 5, 2, 1'b0);
    drain("s2_drain");
    repeat (3) @(negedge sys_clk);
    check_eq("s2_act_count", act_cnt - a0, 0);
    check_eq("s2_row_open", row_open_o, 1);

    // Refresh with the row open: PRE first, then grant.
    p0 = pre_cnt;
    @(posedge sys_clk); #1; refresh_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (refresh_gnt) begin seen = 1; break; end
    end
    check_eq("s3_refresh_gnt", seen, 1);
    check_eq("s3_pre_count", pre_cnt - p0, 1);
    check_eq("s3_row_closed", row_open_o, 0);
    @(posedge sys_clk); #1; refresh_req = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_eq("s3_gnt_dropped", refresh_gnt, 0);

    // Close-page: each write auto-precharges, so the next same-row write needs an ACT.
    @(posedge sys_clk); #1; close_page = 1'b1;
    a0 = act_cnt;
    send(1'b1, 7, 4, 1'b1);
    drain("s4_drain_a");
    repeat (8) @(negedge sys_clk);
    check_eq("s4_row_closed", row_open_o, 0);
    send(1'b1, 7, 5, 1'b1);
    drain("s4_drain_b");
    check_eq("s4_act_count", act_cnt - a0, 2);
    repeat (8) @(negedge sys_clk);
    @(posedge sys_clk); #1; close_page = 1'b0;

    // Idle timeout of 4 after a read, with tRP configured as zero.
    @(posedge sys_clk); #1; idle_timeout_cfg = 8'd4; cfg_tRP = 8'd0;
    p0 = pre_cnt;
    send(1'b0, 9, 1, 1'b0);
    drain("s5_drain");
    rd_cyc = col_cyc;
    for (int i = 0; i < 60 && pre_cnt == p0; i++) @(negedge sys_clk);
    check_eq("s5_pre_count", pre_cnt - p0, 1);
    gap = pre_cyc - rd_cyc;
    check_eq("s5_timeout_gap_ok", (gap >= 4 && gap <= 10), 1);
    repeat (2) @(negedge sys_clk);
    check_eq("s5_row_closed", row_open_o, 0);
    @(posedge sys_clk); #1; idle_timeout_cfg = '0;
    a0 = act_cnt;
    send(1'b0, 9, 2, 1'b0);
    drain("s5_drain_b");
    check_eq("s5_reopen_act", act_cnt - a0, 1);

    // Backpressure: fill buffer + FIFO while commands are stalled.
    @(posedge sys_clk); #1; cmd_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (!req_ready) break;
      exp_q.push_back(mk(1'b0, n, 1'b0));
      req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'((3 << COL_W) | n);
      @(posedge sys_clk); #1;
      req_valid = 1'b0;
      n++;
    end
    check_eq("s6_accepted", n, DEPTH + 1);
    check_eq("s6_full_ready", req_ready, 0);
    check_eq("s6_lock", req_lock, 1);
    @(posedge sys_clk); #1; cmd_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (cmd_valid && cmd_ready && cmd_payload_cas) begin seen = 1; break; end
    end
    check_eq("s6_first_col", seen, 1);
    check_eq("s6_ready_before_pop", req_ready, 0);
    @(negedge sys_clk);
    check_eq("s6_ready_after_pop", req_ready, 1);
    drain("s6_drain");
    repeat (4) @(negedge sys_clk);
    check_eq("s6_lock_clear", req_lock, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
